// File: rtl/onehot_encoder.sv
// Registered one-hot to binary encoder with a stability filter and a valid/ready output.
// Optional macro ONEHOT_PRIORITY_EN: accept multi-hot patterns as their highest set bit.
module onehot_encoder #(
  parameter int WIDTH         = 8,
  parameter int IDX_W         = $clog2(WIDTH),
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     onehot_in,
  output logic [IDX_W-1:0]     idx_out,
  output logic                 idx_valid,
  input  logic                 idx_ready,
  output logic                 err_multi,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 err_clr
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    EMIT   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_ZERO  = 2'd0,
    CLS_ONE   = 2'd1,
    CLS_MULTI = 2'd2
  } cls_t;

  function automatic logic [IDX_W-1:0] hi_index(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] in_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] last_pat_q, last_pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  cls_t             cand_cls;
  logic             err_inc;

  // x & (x-1) clears the lowest set bit; zero afterwards means at most one bit was set.
  always_comb begin
    cand_cls = CLS_MULTI;
    if (cand_q == '0) begin
      cand_cls = CLS_ZERO;
    end else if ((cand_q & (cand_q - WIDTH'(1))) == '0) begin
      cand_cls = CLS_ONE;
    end
  end

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    last_pat_d = last_pat_q;
    idx_d      = idx_q;
    err_inc    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_q != last_pat_q) begin
          cand_d  = in_q;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (in_q != cand_q) begin
          cand_d = in_q;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          last_pat_d = cand_q;
`ifdef ONEHOT_PRIORITY_EN
          if (cand_cls == CLS_ZERO) begin
            state_d = IDLE;
          end else begin
            idx_d   = hi_index(cand_q);
            state_d = EMIT;
          end
`else
          case (cand_cls)
            CLS_ONE: begin
              idx_d   = hi_index(cand_q);
              state_d = EMIT;
            end
            CLS_ZERO: begin
              state_d = IDLE;
            end
            default: begin
              err_inc = 1'b1;
              state_d = IDLE;
            end
          endcase
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      EMIT: begin
        // Input is deliberately ignored here; a lasting change is seen back in IDLE.
        if (idx_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      in_q       <= '0;
      cand_q     <= '0;
      last_pat_q <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_q       <= onehot_in;
      cand_q     <= cand_d;
      last_pat_q <= last_pat_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
    end
  end

  assign idx_out   = idx_q;
  assign idx_valid = (state_q == EMIT);

`ifdef ONEHOT_PRIORITY_EN
  logic unused_err;
  assign unused_err = err_clr ^ err_inc;
  assign err_multi  = 1'b0;
  assign err_count  = '0;
`else
  logic                 err_multi_q, err_multi_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  // Clear takes priority over a same-cycle rejection.
  always_comb begin
    err_multi_d = err_multi_q;
    err_count_d = err_count_q;
    if (err_clr) begin
      err_multi_d = 1'b0;
      err_count_d = '0;
    end else if (err_inc) begin
      err_multi_d = 1'b1;
      if (err_count_q != '1) err_count_d = err_count_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_multi_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_multi_q <= err_multi_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_multi = err_multi_q;
  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_onehot_encoder.sv
// Directed bench for onehot_encoder; inputs driven and outputs sampled on the falling edge.
module tb_onehot_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] onehot_in;
  logic [2:0] idx_out;
  logic       idx_valid;
  logic       idx_ready;
  logic       err_multi;
  logic [3:0] err_count;
  logic       err_clr;

  int checks   = 0;
  int failures = 0;
  int hs_cnt   = 0;
  int hs_bad   = 0;
  int exp_idx  = 0;

  always #5 clk = ~clk;

  onehot_encoder #(
    .WIDTH(8), .IDX_W(3), .STABLE_CYCLES(4), .ERR_CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .onehot_in(onehot_in),
    .idx_out(idx_out), .idx_valid(idx_valid), .idx_ready(idx_ready),
    .err_multi(err_multi), .err_count(err_count), .err_clr(err_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One rising edge, then sample; record completed handshakes.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    if (idx_valid && idx_ready) begin
      hs_cnt++;
      if (int'(idx_out) != exp_idx) hs_bad++;
    end
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    for (int i = 1; i <= max; i++) begin
      cycle();
      if (idx_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic hold(input logic [7:0] pat, input int n);
    onehot_in = pat;
    repeat (n) cycle();
  endtask

  int  n;
  logic stable;

  initial begin
    rst       = 1'b1;
    onehot_in = 8'h00;
    idx_ready = 1'b0;
    err_clr   = 1'b0;
    @(negedge clk);
    repeat (2) cycle();
    check("rst_valid", idx_valid, 0);
    check("rst_idx",   idx_out,   0);
    check("rst_multi", err_multi, 0);
    check("rst_count", err_count, 0);

    // Single held pattern: one emission after 6 edges.
    rst = 1'b0; onehot_in = 8'h20; idx_ready = 1'b1; exp_idx = 5; hs_cnt = 0;
    wait_valid(20, n);
    check("t1_latency", n, 6);
    check("t1_idx", idx_out, 5);
    cycle();
    check("t1_drop", idx_valid, 0);
    repeat (20) cycle();
    check("t1_once", hs_cnt, 1);

    // Bouncing input never settles, then settles at 8'h02.
    hs_cnt = 0; exp_idx = 1;
    for (int k = 0; k < 3; k++) begin
      hold(8'h01, 2);
      hold(8'h02, 2);
    end
    hold(8'h01, 2);
    check("t2_no_emit_bounce", hs_cnt, 0);
    onehot_in = 8'h02;
    wait_valid(20, n);
    check("t2_latency", n, 6);
    check("t2_idx", idx_out, 1);
    repeat (10) cycle();
    check("t2_once", hs_cnt, 1);

    // Backpressure: code held while idx_ready is low.
    idx_ready = 1'b0; onehot_in = 8'h80;
    wait_valid(20, n);
    check("t3_latency", n, 6);
    stable = 1'b1;
    repeat (10) begin
      cycle();
      if (!idx_valid || idx_out != 3'd7) stable = 1'b0;
    end
    check("t3_hold", stable, 1);
    idx_ready = 1'b1;
    cycle();
    check("t3_drop", idx_valid, 0);
    check("t3_idx_kept", idx_out, 7);

    // Alternating multi-hot / zero patterns.
    hold(8'h00, 8);
    hs_cnt = 0; hs_bad = 0; exp_idx = 4;
`ifdef ONEHOT_PRIORITY_EN
    for (int r = 0; r < 20; r++) begin
      hold(8'h11, 8);
      hold(8'h00, 8);
    end
    check("t4p_emits", hs_cnt, 20);
    check("t4p_idx_bad", hs_bad, 0);
    check("t4p_multi", err_multi, 0);
    check("t4p_count", err_count, 0);
`else
    for (int r = 0; r < 20; r++) begin
      hold(8'h11, 8);
      if (r == 0) begin
        check("t4_first_count", err_count, 1);
        check("t4_first_multi", err_multi, 1);
      end
      hold(8'h00, 8);
    end
    check("t4_sat_count", err_count, 15);
    check("t4_sticky", err_multi, 1);
    check("t4_no_emit", hs_cnt, 0);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    check("t4_clr_count", err_count, 0);
    check("t4_clr_multi", err_multi, 0);
    // Clear lands on the same edge as the rejection (edge 6).
    onehot_in = 8'h11;
    repeat (5) cycle();
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    check("t4_clr_wins_count", err_count, 0);
    check("t4_clr_wins_multi", err_multi, 0);
    repeat (10) cycle();
    check("t4_held_not_recounted", err_count, 0);
    hold(8'h00, 8);
`endif

    // Reset while in EMIT, then re-emission.
    idx_ready = 1'b0; onehot_in = 8'h08;
    wait_valid(20, n);
    check("t5_latency", n, 6);
    check("t5_idx", idx_out, 3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t5_rst_valid", idx_valid, 0);
    check("t5_rst_idx", idx_out, 0);
    wait_valid(20, n);
    check("t5_reemit_latency", n, 6);
    check("t5_reemit_idx", idx_out, 3);
    idx_ready = 1'b1;
    cycle();

    // Same code re-emitted after an accepted ZERO.
    hs_cnt = 0; hs_bad = 0; exp_idx = 2;
    hold(8'h04, 8);
    hold(8'h00, 8);
    hold(8'h04, 8);
    check("t6_emits", hs_cnt, 2);
    check("t6_idx_bad", hs_bad, 0);
    check("t6_multi", err_multi, 0);
    check("t6_count", err_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
